// File: rtl/Vermitypes_pkg.sv
// rtl/Vermitypes_pkg.sv - shared Vermicel core types: decoded instruction record and sequencer state
package Vermitypes_pkg;

    typedef struct packed {
        logic has_rd;
        logic is_load;
        logic is_store;
        logic is_trap;
        logic is_mret;
    } instruction_t;

    typedef enum logic [2:0] {
        FETCH     = 3'd0,
        DECODE    = 3'd1,
        EXECUTE   = 3'd2,
        LOAD      = 3'd3,
        STORE     = 3'd4,
        WRITEBACK = 3'd5
    } sequencer_state_t;

    // Width able to hold 0..cycles, never narrower than one bit.
    function automatic int timer_width(input int cycles);
        int w;
        w = $clog2(cycles + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/seq_bus_timer.sv
// rtl/seq_bus_timer.sv - bus wait counter that flags expiry in the last allowed wait cycle
module seq_bus_timer
    import Vermitypes_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic i_clear,
    input  logic i_count_en,
    output logic o_expired
);

    localparam int CW = timer_width(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LIMIT = (TIMEOUT_CYCLES == 0) ? '0 : CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (i_clear) begin
            r_count <= '0;
        end else if (i_count_en && !o_expired) begin
            r_count <= r_count + 1'b1;
        end
    end

    // A zero limit disables expiry entirely; the counter value is then irrelevant.
    assign o_expired = (TIMEOUT_CYCLES != 0) && i_count_en && (r_count == LIMIT);

endmodule

// File: rtl/core_sequencer.sv
// rtl/core_sequencer.sv - multi-cycle fetch/decode/execute/memory/writeback control FSM
module core_sequencer
    import Vermitypes_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  instruction_t     instr,
    input  logic             irq,
    input  logic             bus_ready,
    output logic             bus_valid,
    output logic             bus_fetch,
    output logic             bus_write,
    output logic             fetch_en,
    output logic             decode_en,
    output logic             execute_en,
    output logic             load_en,
    output logic             writeback_en,
    output logic             take_trap,
    output logic             trap_cause_irq,
    output logic             mret_en,
    output logic             bus_fault,
    output sequencer_state_t state
);

    sequencer_state_t r_state;
    sequencer_state_t w_next;
    logic             r_irq_pending;
    logic             r_trap_flag;
    logic             w_bus_state;
    logic             w_count_en;
    logic             w_timer_clear;
    logic             w_expired;
    logic             w_take_trap;
    logic             w_unused_has_rd;

    assign w_unused_has_rd = instr.has_rd;
    assign w_bus_state     = (r_state == FETCH) || (r_state == LOAD) || (r_state == STORE);
    assign w_count_en      = w_bus_state && !bus_ready;
    assign w_take_trap     = r_trap_flag || r_irq_pending;
    assign w_timer_clear   = reset || ((w_next != r_state) &&
                             ((w_next == FETCH) || (w_next == LOAD) || (w_next == STORE)));
    assign state           = r_state;

    seq_bus_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_bus_timer (
        .clk       (clk),
        .i_clear   (w_timer_clear),
        .i_count_en(w_count_en),
        .o_expired (w_expired)
    );

    // Ready wins over expiry in the limit cycle.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            FETCH:       if (bus_ready) w_next = DECODE; else if (w_expired) w_next = WRITEBACK;
            DECODE:      w_next = EXECUTE;
            EXECUTE:     w_next = instr.is_load ? LOAD : (instr.is_store ? STORE : WRITEBACK);
            LOAD, STORE: if (bus_ready || w_expired) w_next = WRITEBACK;
            WRITEBACK:   w_next = FETCH;
            default:     w_next = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= FETCH;
            r_irq_pending <= 1'b0;
            r_trap_flag   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (irq) begin
                r_irq_pending <= 1'b1;
            end else if ((r_state == WRITEBACK) && w_take_trap && !r_trap_flag) begin
                r_irq_pending <= 1'b0;
            end
            if (r_state == WRITEBACK) begin
                r_trap_flag <= 1'b0;
            end else if (((r_state == EXECUTE) && instr.is_trap) || w_expired) begin
                r_trap_flag <= 1'b1;
            end
        end
    end

    always_comb begin
        bus_valid      = 1'b0;
        bus_fetch      = 1'b0;
        bus_write      = 1'b0;
        fetch_en       = 1'b0;
        decode_en      = 1'b0;
        execute_en     = 1'b0;
        load_en        = 1'b0;
        writeback_en   = 1'b0;
        take_trap      = 1'b0;
        trap_cause_irq = 1'b0;
        mret_en        = 1'b0;
        bus_fault      = 1'b0;
        if (!reset) begin
            unique case (r_state)
                FETCH: begin
                    bus_valid = 1'b1;
                    bus_fetch = 1'b1;
                    fetch_en  = bus_ready;
                end
                DECODE:  decode_en  = 1'b1;
                EXECUTE: execute_en = 1'b1;
                LOAD: begin
                    bus_valid = 1'b1;
                    load_en   = bus_ready;
                end
                STORE: begin
                    bus_valid = 1'b1;
                    bus_write = 1'b1;
                end
                WRITEBACK: begin
                    writeback_en   = 1'b1;
                    take_trap      = w_take_trap;
                    trap_cause_irq = !r_trap_flag && r_irq_pending;
                    mret_en        = instr.is_mret && !w_take_trap;
                end
                default: ;
            endcase
            bus_fault = w_expired;
        end
    end

endmodule
